// File: rtl/uart_rx_os_if.sv
// Byte-stream side of the oversampling UART receiver: held word, error flags,
// overrun pulse and the valid/ready handshake.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data_out,
        output valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data_out,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronizer, mid-bit sampling with
// false-start rejection, optional parity, 1/2 stop bits, valid/ready holding register.
module uart_rx_os #(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    output logic          busy,
    uart_rx_os_if.master  bus
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic                 rx_p0, rx_s;
    logic                 armed, armed_n;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr, ferr_fin;
    logic                 tick, sample;
    logic                 shift_en, par_en, stop_en, frame_done;
    logic                 hold_free;

    // Expected parity bit for the received data word.
    function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
        par_bit = (PARITY == 2) ? ~(^d) : ^d;
    endfunction

    // Synchronizer: rx idles high, so both flops reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // The start bit is sampled half-way in; every later bit a full bit later.
    assign tick   = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign sample = tick && (os_cnt == ((state == S_START) ? OS_MID : OS_LAST));
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_n;
            armed <= armed_n;
        end
    end

    always_comb begin
        state_n    = state;
        armed_n    = armed;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        frame_done = 1'b0;
        ferr_fin   = ferr | ~rx_s;
        unique case (state)
            S_IDLE: begin
                if (rx_s) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    par_en  = 1'b1;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    stop_en = 1'b1;
                    if (stop_cnt == STOP_LAST) begin
                        frame_done = 1'b1;
                        state_n    = S_IDLE;
                        // A low line after the frame must go high before the next start.
                        if (!rx_s) begin
                            armed_n = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            div_cnt <= (state == S_IDLE || tick) ? '0 : div_cnt + 1'b1;
            if (state == S_IDLE || sample) begin
                os_cnt <= '0;
            end else if (tick) begin
                os_cnt <= os_cnt + 1'b1;
            end
            if (state == S_IDLE) begin
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
            end else begin
                if (shift_en) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (par_en) begin
                    perr <= (rx_s != par_bit(shreg));
                end
                if (stop_en) begin
                    stop_cnt <= stop_cnt + 1'b1;
                    if (!rx_s) begin
                        ferr <= 1'b1;
                    end
                end
            end
        end
    end

    // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    assign hold_free = !bus.valid || bus.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_out   <= '0;
            bus.valid      <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.overrun <= frame_done && !hold_free;
            if (frame_done && hold_free) begin
                bus.data_out   <= shreg;
                bus.parity_err <= perr;
                bus.frame_err  <= ferr_fin;
                bus.valid      <= 1'b1;
            end else if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three receivers (8N1, 8E1, 8O2) fed by serial frames,
// delivered words checked against a scoreboard of expected frames.
module tb_uart_rx_os;

    localparam int CLK_DIV = 4;
    localparam int OS      = 16;
    localparam int T       = CLK_DIV * OS;

    typedef struct {
        int         idx;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      rx;
    logic [2:0]      rdy;
    logic [2:0][7:0] dout;
    logic [2:0]      vld, pe, fe, ovr, bsy;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   vld_cnt[3];
    int   ovr_cnt[3];
    int   n_lat;
    int   base;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int PAR  = (gi == 0) ? 0 : ((gi == 1) ? 1 : 2);
        localparam int STOP = (gi == 2) ? 2 : 1;

        uart_rx_os_if #(.DATA_BITS(8)) bus ();

        uart_rx_os #(
            .CLK_DIV(CLK_DIV),
            .OVERSAMPLE(OS),
            .DATA_BITS(8),
            .PARITY(PAR),
            .STOP_BITS(STOP)
        ) dut (
            .clk(clk),
            .rst(rst),
            .rx(rx[gi]),
            .busy(bsy[gi]),
            .bus(bus.master)
        );

        assign bus.ready = rdy[gi];
        assign dout[gi]  = bus.data_out;
        assign vld[gi]   = bus.valid;
        assign pe[gi]    = bus.parity_err;
        assign fe[gi]    = bus.frame_err;
        assign ovr[gi]   = bus.overrun;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshakes are observed mid-cycle; each accepted word pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (vld[i]) vld_cnt[i]++;
                if (ovr[i]) ovr_cnt[i]++;
                if (vld[i] && rdy[i]) begin
                    check("sb_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_idx", i, e.idx);
                        check("sb_data", dout[i], e.d);
                        check("sb_parity_err", pe[i], e.pe);
                        check("sb_frame_err", fe[i], e.fe);
                    end
                end
            end
        end
    end

    task automatic bit_out(input int idx, input logic v, input int ncyc);
        rx[idx] = v;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic send_frame(input int idx, input logic [7:0] d, input int par, input int stops,
                              input bit force_p, input logic p_val, input logic s_val, input bit push);
        logic pcalc, pb;
        exp_t e;
        pcalc = (par == 2) ? ~(^d) : ^d;
        pb    = force_p ? p_val : pcalc;
        if (push) begin
            e.idx = idx;
            e.d   = d;
            e.pe  = (par != 0) && (pb != pcalc);
            e.fe  = !s_val;
            exp_q.push_back(e);
        end
        bit_out(idx, 1'b0, T);
        for (int i = 0; i < 8; i++) bit_out(idx, d[i], T);
        if (par != 0) bit_out(idx, pb, T);
        for (int i = 0; i < stops; i++) bit_out(idx, s_val, T);
    endtask

    task automatic check_reset_outputs(input int i);
        check("rst_data_out", dout[i], 0);
        check("rst_valid", vld[i], 0);
        check("rst_parity_err", pe[i], 0);
        check("rst_frame_err", fe[i], 0);
        check("rst_overrun", ovr[i], 0);
        check("rst_busy", bsy[i], 0);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pd;
        rst = 1'b1;
        rx  = 3'b111;
        rdy = 3'b111;
        for (int i = 0; i < 3; i++) begin
            vld_cnt[i] = 0;
            ovr_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_outputs(i);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 8N1 0xA5 with ready high: single-cycle valid, fixed latency.
        base = vld_cnt[0];
        fork
            send_frame(0, 8'hA5, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                n_lat = 0;
                while (n_lat < 1000) begin
                    @(posedge clk);
                    n_lat++;
                    #1;
                    if (vld[0]) break;
                end
                check("t1_latency", n_lat - 2, 609);
            end
        join
        bit_out(0, 1'b1, T);
        check("t1_valid_cycles", vld_cnt[0] - base, 1);
        check("t1_drained", exp_q.size(), 0);

        // Even parity: 0x03 with parity 1 is wrong, 0x07 with parity 1 is right.
        send_frame(1, 8'h03, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(1, 8'h07, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        bit_out(1, 1'b1, 100);
        check("t2_drained", exp_q.size(), 0);

        // Stop bit 0 followed by a long low line, then a clean frame.
        send_frame(0, 8'h3C, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        bit_out(0, 1'b0, 200);
        check("t3_busy_while_low", bsy[0], 0);
        bit_out(0, 1'b1, 100);
        send_frame(0, 8'h55, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1);
        bit_out(0, 1'b1, 100);
        check("t3_drained", exp_q.size(), 0);

        // Short low glitch is a false start.
        base = vld_cnt[0];
        bit_out(0, 1'b0, 16);
        check("t4_busy_on_glitch", bsy[0], 1);
        bit_out(0, 1'b1, T);
        check("t4_busy_after_glitch", bsy[0], 0);
        check("t4_no_valid", vld_cnt[0] - base, 0);
        send_frame(0, 8'h81, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1);
        bit_out(0, 1'b1, 100);
        check("t4_drained", exp_q.size(), 0);

        // Consumer stalled: second frame is dropped with one overrun pulse.
        rdy[0] = 1'b0;
        base = ovr_cnt[0];
        send_frame(0, 8'h11, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h22, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        bit_out(0, 1'b1, 20);
        check("t5_overrun_pulses", ovr_cnt[0] - base, 1);
        check("t5_held_valid", vld[0], 1);
        check("t5_held_data", dout[0], 8'h11);
        rdy[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_valid_after_accept", vld[0], 0);
        check("t5_drained", exp_q.size(), 0);

        // 8O2: reset in the middle of data bit 4 discards the partial frame.
        pd = 8'hF0;
        bit_out(2, 1'b0, T);
        for (int i = 0; i < 4; i++) bit_out(2, pd[i], T);
        bit_out(2, pd[4], T / 2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs(2);
        bit_out(2, 1'b1, 100);
        send_frame(2, 8'h0F, 2, 2, 1'b0, 1'b0, 1'b1, 1'b1);
        bit_out(2, 1'b1, 200);
        check("t6_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
